action_tbl: RTL and testbench

Downstream stage of the 64-entry rule lookup: consumes the `lookup2um_index_valid/hit/index` result stream, maps each result to a 32-bit action word from a configurable 64-entry action table (or a programmable miss action), and presents it to the UM with valid/ready flow control. Results are buffered in an internal FIFO; the block drives the lookup's `um2lookup_alful` back-pressure input. Action table, miss action and statistics are reached over the standard cfg bus (cs_n/wr_rd/ack_n).

---
 rtl/action_tbl_if.sv | 44 ++++
 rtl/action_tbl.sv | 229 ++++++++++++++++++++++
 tb/tb_action_tbl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/action_tbl_if.sv
// action_tbl_if
//   Groups the three buses of the action table stage:
//     - cfg bus      : cfg2act_cs_n/wr_rd/addr/wdata in, act2cfg_ack_n/rdata out
//     - result bus   : lookup2act_index_valid/hit/index in, act2lookup_alful out
//     - UM output    : act2um_action_valid/hit/index/action out, um2act_ready in
//   Output handshake: a transfer happens on every rising clk edge where
//   act2um_action_valid && um2act_ready. While valid is high and ready is
//   low, all act2um_* fields hold. Valid never depends on ready combinationally.
//   slave  = the action table block, master = whoever drives it.
interface action_tbl_if;
  logic        cfg2act_cs_n;
  logic        cfg2act_wr_rd;
  logic        act2cfg_ack_n;
  logic [15:0] cfg2act_addr;
  logic [31:0] cfg2act_wdata;
  logic [31:0] act2cfg_rdata;

  logic        lookup2act_index_valid;
  logic        lookup2act_hit;
  logic [5:0]  lookup2act_index;
  logic        act2lookup_alful;

  logic        act2um_action_valid;
  logic        act2um_hit;
  logic [5:0]  act2um_index;
  logic [31:0] act2um_action;
  logic        um2act_ready;

  modport slave (
    input  cfg2act_cs_n, cfg2act_wr_rd, cfg2act_addr, cfg2act_wdata,
    input  lookup2act_index_valid, lookup2act_hit, lookup2act_index,
    input  um2act_ready,
    output act2cfg_ack_n, act2cfg_rdata, act2lookup_alful,
    output act2um_action_valid, act2um_hit, act2um_index, act2um_action
  );

  modport master (
    output cfg2act_cs_n, cfg2act_wr_rd, cfg2act_addr, cfg2act_wdata,
    output lookup2act_index_valid, lookup2act_hit, lookup2act_index,
    output um2act_ready,
    input  act2cfg_ack_n, act2cfg_rdata, act2lookup_alful,
    input  act2um_action_valid, act2um_hit, act2um_index, act2um_action
  );
endinterface

// File: rtl/action_tbl.sv
// action_tbl
//   Maps each lookup result {hit,index} to a 32-bit action word from a
//   64-entry table (or the miss action on a miss) and hands it to the UM
//   with valid/ready flow control. Results are registered, queued in a
//   FIFO_DEPTH-entry FIFO and popped into an output register.
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : cfg bus, lookup result bus, UM output bus
//   o_dbg_cfg_state  : current cfg FSM state (IDLE/ACCESS/RELEASE)
// Address map (addr[1:0] ignored)
//   0x000-0x0FC table entry addr[7:2]   0x100 miss action
//   0x104 hit counter (write clears)    0x108 miss counter (write clears)
//   0x10C bit0 overflow sticky (write clears); anything else reads 0
module action_tbl #(
  parameter int FIFO_DEPTH = 16,
  parameter int ALFUL_TH   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  action_tbl_if.slave       bus,
  output logic [1:0]        o_dbg_cfg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // cfg side
  logic        r_cs_n_s1, r_cs_n_s2;
  logic [1:0]  r_state;
  logic        r_ack_n;
  logic [31:0] r_rdata;
  logic [31:0] r_table [64];
  logic [31:0] r_miss_act;
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic        r_ovf;

  // result path
  logic          r_in_vld, r_in_hit;
  logic [5:0]    r_in_idx;
  logic [6:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_alful;
  logic          r_out_vld, r_out_hit;
  logic [5:0]    r_out_idx;
  logic [31:0]   r_out_act;

  logic          w_cs_valid, w_cfg_wr;
  logic          w_addr_tbl;
  logic [13:0]   w_word;
  logic [5:0]    w_tbl_idx;
  logic          w_wr_tbl, w_wr_miss, w_clr_hit, w_clr_miss, w_clr_ovf;
  logic [31:0]   w_rd_data;
  logic          w_full, w_empty, w_push, w_pop, w_drop, w_hs;
  logic [AW:0]   w_count_nxt;
  logic [6:0]    w_head;
  logic          w_unused;

  assign w_unused = &{1'b0, bus.cfg2act_addr[1:0]};

  // ---------------------------------------------------------------- cfg bus
  assign w_cs_valid = ~r_cs_n_s2;
  assign w_cfg_wr   = (r_state == ST_ACCESS) & ~bus.cfg2act_wr_rd;
  assign w_addr_tbl = (bus.cfg2act_addr[15:8] == 8'h00);
  assign w_word     = bus.cfg2act_addr[15:2];
  assign w_tbl_idx  = bus.cfg2act_addr[7:2];
  assign w_wr_tbl   = w_cfg_wr & w_addr_tbl;
  assign w_wr_miss  = w_cfg_wr & (w_word == 14'h0040);
  assign w_clr_hit  = w_cfg_wr & (w_word == 14'h0041);
  assign w_clr_miss = w_cfg_wr & (w_word == 14'h0042);
  assign w_clr_ovf  = w_cfg_wr & (w_word == 14'h0043);

  always_comb begin
    w_rd_data = '0;
    if (w_addr_tbl) begin
      w_rd_data = r_table[w_tbl_idx];
    end else begin
      case (w_word)
        14'h0040: w_rd_data = r_miss_act;
        14'h0041: w_rd_data = r_hit_cnt;
        14'h0042: w_rd_data = r_miss_cnt;
        14'h0043: w_rd_data = {31'd0, r_ovf};
        default:  w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_n_s1 <= 1'b1;
      r_cs_n_s2 <= 1'b1;
    end else begin
      r_cs_n_s1 <= bus.cfg2act_cs_n;
      r_cs_n_s2 <= r_cs_n_s1;
    end
  end

  // One access per cs_n assertion: RELEASE waits for cs to drop first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack_n <= 1'b1;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_valid) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.cfg2act_wr_rd) r_rdata <= w_rd_data;
          r_ack_n <= 1'b0;
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_cs_valid) begin
            r_ack_n <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack_n <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) r_table[i] <= '0;
      r_miss_act <= '0;
    end else begin
      if (w_wr_tbl)  r_table[w_tbl_idx] <= bus.cfg2act_wdata;
      if (w_wr_miss) r_miss_act         <= bus.cfg2act_wdata;
    end
  end

  // Clear-by-write beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_clr_hit)              r_hit_cnt  <= '0;
      else if (w_hs && r_out_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_clr_miss)              r_miss_cnt <= '0;
      else if (w_hs && !r_out_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  // A drop in the same cycle as a clear still leaves the sticky set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (w_clr_ovf) r_ovf <= 1'b0;
  end

  // ------------------------------------------------------------ result path
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rptr];
  assign w_hs        = r_out_vld & bus.um2act_ready;
  assign w_pop       = ~w_empty & (~r_out_vld | bus.um2act_ready);
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign w_push      = r_in_vld & (~w_full | w_pop);
  assign w_drop      = r_in_vld & w_full & ~w_pop;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_vld <= 1'b0;
      r_in_hit <= 1'b0;
      r_in_idx <= '0;
    end else begin
      r_in_vld <= bus.lookup2act_index_valid;
      r_in_hit <= bus.lookup2act_hit;
      r_in_idx <= bus.lookup2act_index;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_in_hit, r_in_idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_alful <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_alful <= (w_count_nxt >= (AW+1)'(ALFUL_TH));
    end
  end

  // Table/miss action are sampled at the load edge, so a cfg write landing
  // on the same edge is seen only by later loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_hit <= 1'b0;
      r_out_idx <= '0;
      r_out_act <= '0;
    end else if (w_pop) begin
      r_out_vld <= 1'b1;
      r_out_hit <= w_head[6];
      r_out_idx <= w_head[5:0];
      r_out_act <= w_head[6] ? r_table[w_head[5:0]] : r_miss_act;
    end else if (bus.um2act_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign bus.act2cfg_ack_n       = r_ack_n;
  assign bus.act2cfg_rdata       = r_rdata;
  assign bus.act2lookup_alful    = r_alful;
  assign bus.act2um_action_valid = r_out_vld;
  assign bus.act2um_hit          = r_out_hit;
  assign bus.act2um_index        = r_out_idx;
  assign bus.act2um_action       = r_out_act;
  assign o_dbg_cfg_state         = r_state;

endmodule

// File: tb/tb_action_tbl.sv
module tb_action_tbl;
  localparam int W = 39;   // {hit, index[5:0], action[31:0]}

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  action_tbl_if u_if();

  action_tbl #(.FIFO_DEPTH(16), .ALFUL_TH(10)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (u_if.slave),
    .o_dbg_cfg_state (dbg_state)
  );

  // ---------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  mdl_tbl [64];
  logic [31:0]  mdl_miss;
  int unsigned  mdl_hit_cnt;
  int unsigned  mdl_miss_cnt;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;   // write data, or expected read data
  } cfg_vec_t;

  cfg_vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------- reference model
  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl_tbl[i] = '0;
    mdl_miss     = '0;
    mdl_hit_cnt  = 0;
    mdl_miss_cnt = 0;
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [31:0] data);
    if (addr < 16'h0100) mdl_tbl[addr[7:2]] = data;
    else if (addr[15:2] == 14'h0040) mdl_miss = data;
    else if (addr[15:2] == 14'h0041) mdl_hit_cnt = 0;
    else if (addr[15:2] == 14'h0042) mdl_miss_cnt = 0;
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic inj(input logic h, input logic [5:0] idx);
    u_if.lookup2act_index_valid = 1'b1;
    u_if.lookup2act_hit         = h;
    u_if.lookup2act_index       = idx;
    exp_q.push_back({h, idx, h ? mdl_tbl[idx] : mdl_miss});
  endtask

  task automatic no_inj();
    u_if.lookup2act_index_valid = 1'b0;
  endtask

  task automatic cfg_acc(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat_f, output int lat_r);
    u_if.cfg2act_cs_n  = 1'b0;
    u_if.cfg2act_wr_rd = ~wr;
    u_if.cfg2act_addr  = addr;
    u_if.cfg2act_wdata = wd;
    lat_f = 0;
    while (u_if.act2cfg_ack_n !== 1'b0 && lat_f < 20) begin
      tick();
      lat_f++;
    end
    if (u_if.act2cfg_ack_n !== 1'b0) check("cfg_ack_fall_timeout", 32'(u_if.act2cfg_ack_n), 32'd0);
    rd = u_if.act2cfg_rdata;
    u_if.cfg2act_cs_n = 1'b1;
    lat_r = 0;
    while (u_if.act2cfg_ack_n !== 1'b1 && lat_r < 20) begin
      tick();
      lat_r++;
    end
    if (u_if.act2cfg_ack_n !== 1'b1) check("cfg_ack_rise_timeout", 32'(u_if.act2cfg_ack_n), 32'd1);
  endtask

  task automatic cfg_wr(input logic [15:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    int lf, lr;
    cfg_acc(1'b1, addr, data, rd, lf, lr);
    model_write(addr, data);
  endtask

  task automatic cfg_rd(input logic [15:0] addr, output logic [31:0] data);
    int lf, lr;
    cfg_acc(1'b0, addr, 32'd0, data, lf, lr);
  endtask

  task automatic wait_drain(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      tick();
      cnt++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack_n"},  32'(u_if.act2cfg_ack_n),       32'd1);
    check({tag, "_rdata"},  u_if.act2cfg_rdata,            32'd0);
    check({tag, "_alful"},  32'(u_if.act2lookup_alful),    32'd0);
    check({tag, "_valid"},  32'(u_if.act2um_action_valid), 32'd0);
    check({tag, "_hit"},    32'(u_if.act2um_hit),          32'd0);
    check({tag, "_index"},  32'(u_if.act2um_index),        32'd0);
    check({tag, "_action"}, u_if.act2um_action,            32'd0);
    check({tag, "_state"},  32'(dbg_state),                32'd0);
  endtask

  // ---------------------------------------------------- scoreboard
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && u_if.act2um_action_valid && u_if.um2act_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_hit",    32'(u_if.act2um_hit),   32'(mon_e[38]));
        check("out_index",  32'(u_if.act2um_index), 32'(mon_e[37:32]));
        check("out_action", u_if.act2um_action,     mon_e[31:0]);
        if (mon_e[38]) mdl_hit_cnt++;
        else           mdl_miss_cnt++;
      end
    end
  end

  // ---------------------------------------------------- test sequence
  logic [31:0]  rd;
  logic [W-1:0] head;
  int           lf, lr;

  initial begin
    u_if.cfg2act_cs_n           = 1'b1;
    u_if.cfg2act_wr_rd          = 1'b1;
    u_if.cfg2act_addr           = '0;
    u_if.cfg2act_wdata          = '0;
    u_if.lookup2act_index_valid = 1'b0;
    u_if.lookup2act_hit         = 1'b0;
    u_if.lookup2act_index       = '0;
    u_if.um2act_ready           = 1'b0;
    model_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();

    // ---- table-driven cfg accesses
    vecs[0]  = '{1'b1, 16'h000C, 32'hA5A5_0003};
    vecs[1]  = '{1'b0, 16'h000C, 32'hA5A5_0003};
    vecs[2]  = '{1'b0, 16'h0200, 32'h0000_0000};
    vecs[3]  = '{1'b1, 16'h0200, 32'h1234_5678};
    vecs[4]  = '{1'b0, 16'h0200, 32'h0000_0000};
    vecs[5]  = '{1'b1, 16'h0100, 32'h0000_00FF};
    vecs[6]  = '{1'b0, 16'h0100, 32'h0000_00FF};
    vecs[7]  = '{1'b1, 16'h000C, 32'h0000_0011};
    vecs[8]  = '{1'b0, 16'h000F, 32'h0000_0011};
    vecs[9]  = '{1'b1, 16'h00FC, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 16'h00FC, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 16'h0104, 32'h0000_0000};
    vecs[12] = '{1'b1, 16'h0104, 32'hFFFF_FFFF};
    vecs[13] = '{1'b0, 16'h0108, 32'h0000_0000};
    vecs[14] = '{1'b0, 16'h010C, 32'h0000_0000};
    vecs[15] = '{1'b0, 16'h0010, 32'h0000_0000};
    for (int i = 0; i < 16; i++) begin
      cfg_acc(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lf, lr);
      check($sformatf("vec%0d_ack_fall_lat", i), 32'(lf), 32'd4);
      check($sformatf("vec%0d_ack_rise_lat", i), 32'(lr), 32'd3);
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].data);
      else            check($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
    end

    // ---- hit then miss, latency and throughput
    u_if.um2act_ready = 1'b1;
    tick();
    inj(1'b1, 6'd3);
    tick();
    inj(1'b0, 6'h3f);
    tick();
    no_inj();
    @(negedge clk);
    check("lat_not_yet_valid", 32'(u_if.act2um_action_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_first_valid",  32'(u_if.act2um_action_valid), 32'd1);
    check("lat_first_action", u_if.act2um_action, mdl_tbl[3]);
    tick();
    @(negedge clk);
    check("lat_second_valid",  32'(u_if.act2um_action_valid), 32'd1);
    check("lat_second_action", u_if.act2um_action, mdl_miss);
    tick(3);
    cfg_rd(16'h0104, rd);
    check("hit_cnt_after_pair", rd, 32'(mdl_hit_cnt));
    cfg_rd(16'h0108, rd);
    check("miss_cnt_after_pair", rd, 32'(mdl_miss_cnt));

    // ---- fill, almost-full, overflow, hold stability
    u_if.um2act_ready = 1'b0;
    inj(1'b1, 6'd63);                 // occupies the output register
    tick();
    no_inj();
    tick(3);
    for (int i = 0; i < 9; i++) begin
      inj(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      tick();
    end
    no_inj();
    tick(3);
    check("alful_at_9", 32'(u_if.act2lookup_alful), 32'd0);
    inj(1'b1, 6'd3);
    tick();
    no_inj();
    tick(3);
    check("alful_at_10", 32'(u_if.act2lookup_alful), 32'd1);
    for (int i = 0; i < 6; i++) begin
      inj(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      tick();
    end
    no_inj();
    tick(3);
    cfg_rd(16'h010C, rd);
    check("ovf_at_full", rd, 32'd0);
    u_if.lookup2act_index_valid = 1'b1;   // dropped: no expected entry
    u_if.lookup2act_hit         = 1'b1;
    u_if.lookup2act_index       = 6'd0;
    tick();
    no_inj();
    tick(3);
    cfg_rd(16'h010C, rd);
    check("ovf_after_drop", rd, 32'd1);
    head = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", i),  32'(u_if.act2um_action_valid), 32'd1);
      check($sformatf("hold%0d_index", i),  32'(u_if.act2um_index), 32'(head[37:32]));
      check($sformatf("hold%0d_action", i), u_if.act2um_action, head[31:0]);
      tick();
    end
    cfg_rd(16'h0104, rd);
    check("hit_cnt_during_hold", rd, 32'(mdl_hit_cnt));
    u_if.um2act_ready = 1'b1;
    wait_drain("drain_after_fill");
    tick(3);
    check("alful_after_drain", 32'(u_if.act2lookup_alful), 32'd0);
    cfg_wr(16'h010C, 32'h0);
    cfg_rd(16'h010C, rd);
    check("ovf_cleared", rd, 32'd0);

    // ---- cfg write landing on the load edge: old value out, new next
    fork
      cfg_acc(1'b1, 16'h0014, 32'h22, rd, lf, lr);
      begin
        tick();
        inj(1'b1, 6'd5);
        tick();
        no_inj();
      end
    join
    model_write(16'h0014, 32'h22);
    wait_drain("drain_same_cycle_old");
    inj(1'b1, 6'd5);
    tick();
    no_inj();
    wait_drain("drain_same_cycle_new");

    // ---- randomized traffic against the model
    for (int i = 0; i < 8; i++) cfg_wr(16'(i * 4), $urandom);
    for (int c = 0; c < 400; c++) begin
      u_if.um2act_ready = ($urandom_range(0, 3) != 0);
      if (exp_q.size() < 12 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 2) == 0) inj(1'b0, 6'h3f);
        else                           inj(1'b1, 6'($urandom_range(0, 7)));
      end else begin
        no_inj();
      end
      tick();
    end
    no_inj();
    u_if.um2act_ready = 1'b1;
    wait_drain("drain_random");
    tick(2);
    cfg_rd(16'h0104, rd);
    check("hit_cnt_random", rd, 32'(mdl_hit_cnt));
    cfg_rd(16'h0108, rd);
    check("miss_cnt_random", rd, 32'(mdl_miss_cnt));
    cfg_wr(16'h0104, 32'h0);
    cfg_rd(16'h0104, rd);
    check("hit_cnt_cleared", rd, 32'(mdl_hit_cnt));

    // ---- reset with results buffered and cfg ack pending
    u_if.um2act_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inj(1'b1, 6'(i));
      tick();
    end
    no_inj();
    tick(3);
    u_if.cfg2act_cs_n  = 1'b0;
    u_if.cfg2act_wr_rd = 1'b1;
    u_if.cfg2act_addr  = 16'h0100;
    tick(5);
    check("ack_pending_before_reset", 32'(u_if.act2cfg_ack_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    model_reset();
    u_if.cfg2act_cs_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    u_if.um2act_ready = 1'b1;
    tick(20);
    @(negedge clk);
    check("no_output_after_reset", 32'(u_if.act2um_action_valid), 32'd0);
    tick();
    cfg_rd(16'h000C, rd);
    check("tbl3_after_reset", rd, mdl_tbl[3]);
    cfg_rd(16'h0100, rd);
    check("miss_after_reset", rd, mdl_miss);
    cfg_rd(16'h0104, rd);
    check("hit_cnt_after_reset", rd, 32'(mdl_hit_cnt));
    cfg_rd(16'h010C, rd);
    check("ovf_after_reset", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
